// File: rtl/n2t_pkg.sv
// rtl/n2t_pkg.sv - shared word/address sizing for the n2t memory blocks
package n2t_pkg;

  // Default data word width used by ram8 and its neighbouring memories
  localparam int RAM_WIDTH  = 16;
  // Default address width; depth is exactly 2**RAM_ADDR_W, so no out-of-range addresses exist
  localparam int RAM_ADDR_W = 3;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

endpackage

// File: rtl/register16.sv
// rtl/register16.sv - single storage word with load enable and synchronous clear
module register16
  import n2t_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  // Clear wins over load; otherwise capture in when loaded, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/ram8.sv
// rtl/ram8.sv - eight-word RAM built from register16 words, combinational read
module ram8
  import n2t_pkg::*;
#(
  parameter int WIDTH  = RAM_WIDTH,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] load_sel;
  logic [WIDTH-1:0] words [DEPTH];

  // One-hot write decode; all-zero when load is low so a bad address cannot write
  always_comb begin
    load_sel = '0;
    if (load) begin
      load_sel[address] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    register16 #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .load  (load_sel[i]),
      .out   (words[i])
    );
  end

  // Zero-latency read of the currently addressed word; no write-through bypass
  always_comb begin
    out = words[address];
  end

endmodule

// File: tb/tb_ram8.sv
// tb/tb_ram8.sv - self-checking bench for ram8: vector table, corner sequences, random vs model
module tb_ram8;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [2:0]  address;
  logic [15:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model [8];

  typedef struct {
    string       name;
    bit          rst;
    bit          ld;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp_pre;
    logic [15:0] exp_post;
  } vec_t;

  vec_t vecs [$];

  ram8 dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .load    (load),
    .address (address),
    .out     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample before the edge, then #1 after it; model tracks storage
  task automatic cycle(input bit rst, input bit ld, input logic [2:0] a, input logic [15:0] d,
                       output logic [15:0] pre, output logic [15:0] post);
    @(negedge clk);
    reset = rst; load = ld; address = a; din = d;
    #1;
    pre = dout;
    @(posedge clk);
    #1;
    post = dout;
    if (rst) begin
      for (int k = 0; k < 8; k++) model[k] = 16'h0000;
    end else if (ld) begin
      model[a] = d;
    end
  endtask

  function automatic vec_t mk(input string n, input bit r, input bit l, input int a,
                              input logic [15:0] d, input logic [15:0] p, input logic [15:0] q);
    vec_t v;
    v.name = n; v.rst = r; v.ld = l; v.a = 3'(a); v.d = d; v.exp_pre = p; v.exp_post = q;
    return v;
  endfunction

  initial begin
    logic [15:0] pre, post;
    logic [2:0]  ra;
    logic [15:0] rd;
    bit          rr, rl;

    reset = 1'b0; load = 1'b0; address = '0; din = '0;

    // Vector table, applied in order right after the initial reset edge
    for (int i = 0; i < 8; i++) vecs.push_back(mk($sformatf("sweep0_a%0d", i), 0, 0, i, 16'h0, 16'h0000, 16'h0000));
    vecs.push_back(mk("wr3_a5a5", 0, 1, 3, 16'hA5A5, 16'h0000, 16'hA5A5));
    vecs.push_back(mk("rd3",      0, 0, 3, 16'h0000, 16'hA5A5, 16'hA5A5));
    vecs.push_back(mk("rd2",      0, 0, 2, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("wr5_1234", 0, 1, 5, 16'h1234, 16'h0000, 16'h1234));
    vecs.push_back(mk("wr5_ffff", 0, 1, 5, 16'hFFFF, 16'h1234, 16'hFFFF));
    vecs.push_back(mk("wr0_seed", 0, 1, 0, 16'h5555, 16'h0000, 16'h5555));
    vecs.push_back(mk("rst_beef", 1, 1, 0, 16'hBEEF, 16'h5555, 16'h0000));
    vecs.push_back(mk("rd5_clr",  0, 0, 5, 16'h0000, 16'h0000, 16'h0000));

    // Initial reset edge; storage before this is undefined
    cycle(1, 1, 3'd4, 16'hDEAD, pre, post);
    chk("reset_state", post, 16'h0000);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].ld, vecs[i].a, vecs[i].d, pre, post);
      chk({vecs[i].name, "_pre"}, pre, vecs[i].exp_pre);
      chk({vecs[i].name, "_post"}, post, vecs[i].exp_post);
    end

    // Fill every word, then read back in reverse order
    for (int i = 0; i < 8; i++) cycle(0, 1, 3'(i), 16'h1000 + 16'(i), pre, post);
    for (int i = 7; i >= 0; i--) begin
      cycle(0, 0, 3'(i), 16'hFFFF, pre, post);
      chk($sformatf("fill_rd%0d", i), pre, 16'h1000 + 16'(i));
    end

    // Address change alone within one cycle updates out immediately
    @(negedge clk);
    load = 1'b0; address = 3'd1; #1;
    chk("addr_mid_1", dout, 16'h1001);
    address = 3'd6; #1;
    chk("addr_mid_6", dout, 16'h1006);

    // Back-to-back writes to the same address keep the last one, neighbours untouched
    cycle(0, 1, 3'd2, 16'hAAAA, pre, post);
    cycle(0, 1, 3'd2, 16'hBBBB, pre, post);
    chk("b2b_pre", pre, 16'hAAAA);
    chk("b2b_post", post, 16'hBBBB);
    cycle(0, 0, 3'd1, 16'h0, pre, post);
    chk("b2b_neigh1", pre, 16'h1001);
    cycle(0, 0, 3'd3, 16'h0, pre, post);
    chk("b2b_neigh3", pre, 16'h1003);

    // Unknown address with load low must not disturb storage
    @(negedge clk);
    load = 1'b0; din = 16'hFFFF; address = 3'bx;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 3'(i), 16'h0, pre, post);
      chk($sformatf("xaddr_a%0d", i), pre, (i == 2) ? 16'hBBBB : 16'h1000 + 16'(i));
    end

    // Mid-sequence reset clears everything; a later write to 6 still lands
    cycle(1, 0, 3'd7, 16'h0, pre, post);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 3'(i), 16'h0, pre, post);
      chk($sformatf("postrst_a%0d", i), pre, 16'h0000);
    end
    cycle(0, 1, 3'd6, 16'h6666, pre, post);
    chk("postrst_wr6", post, 16'h6666);
    cycle(0, 0, 3'd5, 16'h0, pre, post);
    chk("postrst_rd5", pre, 16'h0000);

    // Randomised traffic compared against the array model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] exp_pre;
      rr = ($urandom_range(0, 31) == 0);
      rl = $urandom_range(0, 1) == 1;
      ra = 3'($urandom_range(0, 7));
      rd = 16'($urandom);
      exp_pre = model[ra];
      cycle(rr, rl, ra, rd, pre, post);
      chk($sformatf("rnd%0d_pre", n), pre, exp_pre);
      chk($sformatf("rnd%0d_post", n), post, model[ra]);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_pre;
      exp_pre = model[i];
      cycle(0, 0, 3'(i), 16'h0, pre, post);
      chk($sformatf("final_a%0d", i), pre, exp_pre);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram8.md
RAM8 -- requirements
Module: ram8

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; depth is 2**ADDR_W = 8 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 in  input  WIDTH  write data.
REQ-006 load  input  1  write enable for the word selected by address.
REQ-007 address  input  ADDR_W  selects the word to write and the word driven on out.
REQ-008 out  output  WIDTH  contents of the word selected by address.

Function
REQ-009 The block SHALL hold 8 independent WIDTH-bit storage words, indexed 0..7.
REQ-010 On a rising edge with reset=0 and load=1, word[address] SHALL take the value of in; all other words SHALL hold.
REQ-011 On a rising edge with reset=0 and load=0, all words SHALL hold.
REQ-012 Write decode SHALL be one-hot: at most one word is written per edge; no word is written when load=0.
REQ-013 out SHALL be a combinational function of the current address and stored words, with zero-cycle read latency.
REQ-014 In a write cycle, out SHALL show the old word[address] before the edge and the new value after the edge; there is no write-through bypass.
REQ-015 A change of address alone SHALL change out within the same cycle and SHALL never modify storage.
REQ-016 Back-to-back writes to the same address on consecutive edges SHALL leave the last written value; writes to distinct addresses SHALL not interfere.
REQ-017 Address values 0 and 7 SHALL behave identically to the other addresses; there is no wrap-around or out-of-range case, because ADDR_W covers depth exactly.
REQ-018 X or Z on address SHALL NOT corrupt any word when load=0.

Reset
REQ-019 On a rising edge with reset=1, all 8 words SHALL become 0, regardless of load, address or in.
REQ-020 reset SHALL take priority over a simultaneous load=1; no write occurs on that edge.
REQ-021 After a reset edge, out SHALL read 0 for every address until a subsequent write.
REQ-022 Reset asserted mid-sequence, between writes, SHALL discard all previously written data on that edge.
REQ-023 Before the first reset edge, the storage contents are undefined and SHALL NOT be relied on by the bench.

Structure
REQ-024 WIDTH, ADDR_W and DEPTH defaults SHALL live in the shared project package/include, n2t_pkg, and SHALL be reused by the neighbouring memory blocks.
REQ-025 Each word SHALL be one instance of sub-module register16 with ports clk, reset, in, load and out; it holds its value when load=0 and clears when reset=1.
REQ-026 ram8 SHALL contain only the 8 register16 instances, the 3-to-8 load decode, and the 8:1 WIDTH-bit read selection.
REQ-027 The block SHALL contain no latches; storage SHALL exist only inside register16.

Verification
REQ-028 Reset then sweep address 0..7 with load=0 -> out=16'h0000 at every address.
REQ-029 Write 16'hA5A5 at addr 3, then read addr 3 and addr 2 -> 16'hA5A5 and 16'h0000 respectively.
REQ-030 Write word[i]=16'h1000+i for i=0..7, then read in the order 7..0 -> each read returns 16'h1000+i.
REQ-031 Set addr 5 to 16'h1234, then apply load=1, in=16'hFFFF, addr 5 -> out=16'h1234 before the edge and 16'hFFFF after it.
REQ-032 Apply reset=1 together with load=1, in=16'hBEEF, addr 0 -> word 0 reads 16'h0000 after the edge.
REQ-033 Fill all words, then apply reset=1 for one edge -> all 8 addresses read 0, and a later write to addr 6 succeeds.
